// File: rtl/lock_attempt_supervisor_if.sv
// Pin bundle between the lock supervisor and the board/bench:
// raw button and switch inputs plus the status outputs.
interface lock_attempt_supervisor_if #(
    parameter int CODE_LEN  = 7,
    parameter int MAX_FAILS = 3
);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int DW = $clog2(CODE_LEN + 1);

    logic          X;
    logic          Enter_n;
    logic          Lock_n;
    logic          Open;
    logic          Locked_Out;
    logic [FW-1:0] Fail_Count;
    logic [DW-1:0] Digit_Count;
    logic [1:0]    State;

    modport master (
        output X, Enter_n, Lock_n,
        input  Open, Locked_Out, Fail_Count, Digit_Count, State
    );

    modport slave (
        input  X, Enter_n, Lock_n,
        output Open, Locked_Out, Fail_Count, Digit_Count, State
    );
endinterface

// File: rtl/lock_attempt_supervisor.sv
// Digital lock supervisor: conditions the raw push-buttons, collects
// switch-entered code bits, judges complete entries and enforces a timed
// lockout after too many consecutive failures.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_ENTRY   | collecting code bits, Digit_Count = bits so far
// ST_OPEN    | correct code accepted, door open until Lock press
// ST_LOCKOUT | too many failures, all presses ignored until timer = 0
// (value 3)  | unused, falls back to ST_ENTRY on the next clock
module lock_attempt_supervisor #(
    parameter int                  CODE_LEN        = 7,
    parameter logic [CODE_LEN-1:0] CODE            = 7'b1110111,
    parameter int                  MAX_FAILS       = 3,
    parameter int                  LOCKOUT_CYCLES  = 250_000_000,
    parameter int                  DEBOUNCE_CYCLES = 500_000
) (
    input logic                      Clock,
    input logic                      Reset_n,
    lock_attempt_supervisor_if.slave bus
);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int DW = $clog2(CODE_LEN + 1);

    localparam logic [19:0]   DB_LAST    = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]   LOCK_LOAD  = 32'(LOCKOUT_CYCLES - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAILS - 1);
    localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAILS);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    // bit 0 = Enter, bit 1 = Lock
    logic          r_x_s1, r_x_s2;
    logic [1:0]    r_btn_s1, r_btn_s2;
    logic [1:0]    r_db_level;
    logic [19:0]   r_db_cnt [2];
    logic [1:0]    r_press;

    state_t        r_state, w_state_nxt;
    logic [FW-1:0] r_fail, w_fail_nxt;
    logic [DW-1:0] r_digit, w_digit_nxt;
    logic [CODE_LEN-1:0] r_entry, w_entry_nxt, w_shift;
    logic [31:0]   r_timer, w_timer_nxt;
    logic          r_open, r_locked_out;

    logic          w_enter_p, w_lock_p;

    // Lock wins over a coincident Enter, so Enter is masked here.
    assign w_lock_p  = r_press[1];
    assign w_enter_p = r_press[0] & ~r_press[1];

    // two-flop synchronisers for the code switch and both buttons
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x_s1   <= 1'b0;
            r_x_s2   <= 1'b0;
            r_btn_s1 <= 2'b11;
            r_btn_s2 <= 2'b11;
        end else begin
            r_x_s1   <= bus.X;
            r_x_s2   <= r_x_s1;
            r_btn_s1 <= {bus.Lock_n, bus.Enter_n};
            r_btn_s2 <= r_btn_s1;
        end
    end

    // debounce both buttons; strobe for one cycle when a press is accepted
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_db_level  <= 2'b11;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
            r_press     <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_press[i] <= 1'b0;
                if (r_btn_s2[i] == r_db_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_level[i] <= r_btn_s2[i];
                    r_db_cnt[i]   <= '0;
                    r_press[i]    <= ~r_btn_s2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 20'd1;
                end
            end
        end
    end

    // supervisor state and datapath registers; status flags follow next state
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= ST_ENTRY;
            r_fail       <= '0;
            r_digit      <= '0;
            r_entry      <= '0;
            r_timer      <= '0;
            r_open       <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fail       <= w_fail_nxt;
            r_digit      <= w_digit_nxt;
            r_entry      <= w_entry_nxt;
            r_timer      <= w_timer_nxt;
            r_open       <= (w_state_nxt == ST_OPEN);
            r_locked_out <= (w_state_nxt == ST_LOCKOUT);
        end
    end

    // next-state logic: judge only on the strobe that completes an entry
    always_comb begin
        w_state_nxt = r_state;
        w_fail_nxt  = r_fail;
        w_digit_nxt = r_digit;
        w_entry_nxt = r_entry;
        w_timer_nxt = r_timer;
        w_shift     = CODE_LEN'({r_entry, r_x_s2});
        case (r_state)
            ST_ENTRY: begin
                if (w_lock_p) begin
                    w_digit_nxt = '0;
                    w_entry_nxt = '0;
                end else if (w_enter_p) begin
                    if (r_digit == DIGIT_LAST) begin
                        w_digit_nxt = '0;
                        w_entry_nxt = '0;
                        if (w_shift == CODE) begin
                            w_state_nxt = ST_OPEN;
                            w_fail_nxt  = '0;
                        end else if (r_fail >= FAIL_LAST) begin
                            w_state_nxt = ST_LOCKOUT;
                            w_fail_nxt  = FAIL_MAX;
                            w_timer_nxt = LOCK_LOAD;
                        end else begin
                            w_fail_nxt = r_fail + FW'(1);
                        end
                    end else begin
                        w_digit_nxt = r_digit + DW'(1);
                        w_entry_nxt = w_shift;
                    end
                end
            end
            ST_OPEN: begin
                if (w_lock_p) begin
                    w_state_nxt = ST_ENTRY;
                    w_fail_nxt  = '0;
                    w_digit_nxt = '0;
                    w_entry_nxt = '0;
                end
            end
            ST_LOCKOUT: begin
                if (r_timer == 32'd0) begin
                    w_state_nxt = ST_ENTRY;
                    w_fail_nxt  = '0;
                    w_digit_nxt = '0;
                    w_entry_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - 32'd1;
                end
            end
            default: begin
                w_state_nxt = ST_ENTRY;
            end
        endcase
    end

    assign bus.State       = r_state;
    assign bus.Open        = r_open;
    assign bus.Locked_Out  = r_locked_out;
    assign bus.Fail_Count  = r_fail;
    assign bus.Digit_Count = r_digit;
endmodule

// File: tb/tb_lock_attempt_supervisor.sv
// Bench for lock_attempt_supervisor: a table of button presses with
// expected status, hand-written debounce/lockout/reset sequences, and
// random presses checked against a queue-based model of the lock rules.
module tb_lock_attempt_supervisor;
    localparam int CODE_LEN  = 7;
    localparam int MAX_FAILS = 3;
    localparam int LOCKOUT   = 20;
    localparam int DEBOUNCE  = 4;
    localparam logic [CODE_LEN-1:0] CODE = 7'b1110111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lock_attempt_supervisor_if #(.CODE_LEN(CODE_LEN), .MAX_FAILS(MAX_FAILS)) bus ();

    lock_attempt_supervisor #(
        .CODE_LEN(CODE_LEN), .CODE(CODE), .MAX_FAILS(MAX_FAILS),
        .LOCKOUT_CYCLES(LOCKOUT), .DEBOUNCE_CYCLES(DEBOUNCE)
    ) dut (
        .Clock(clk), .Reset_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int fc, input int dc);
        chk({tag, ".state"},      int'(bus.State),       st);
        chk({tag, ".fail"},       int'(bus.Fail_Count),  fc);
        chk({tag, ".digit"},      int'(bus.Digit_Count), dc);
        chk({tag, ".open"},       int'(bus.Open),        (st == 1) ? 1 : 0);
        chk({tag, ".locked_out"}, int'(bus.Locked_Out),  (st == 2) ? 1 : 0);
    endtask

    // ---------------- reference model ----------------
    bit m_bits[$];
    int m_fail;
    bit m_open, m_locked;

    function automatic void model_reset();
        m_bits.delete();
        m_fail   = 0;
        m_open   = 1'b0;
        m_locked = 1'b0;
    endfunction

    function automatic void model_press(input bit en, input bit lk, input bit x);
        int v;
        if (m_locked) return;
        if (lk) begin
            if (m_open) begin
                m_open = 1'b0;
                m_fail = 0;
            end
            m_bits.delete();
        end else if (en && !m_open) begin
            m_bits.push_back(x);
            if (m_bits.size() == CODE_LEN) begin
                v = 0;
                foreach (m_bits[i]) v = v * 2 + int'(m_bits[i]);
                if (v == int'(CODE)) begin
                    m_open = 1'b1;
                    m_fail = 0;
                end else begin
                    m_fail++;
                    if (m_fail >= MAX_FAILS) m_locked = 1'b1;
                end
                m_bits.delete();
            end
        end
    endfunction

    task automatic expect_model(input string tag);
        chk_all(tag, m_locked ? 2 : (m_open ? 1 : 0),
                m_locked ? MAX_FAILS : m_fail, m_bits.size());
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        bus.X       = 1'b0;
        bus.Enter_n = 1'b1;
        bus.Lock_n  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    // One clean press: X settles, button(s) held 6 clocks, then released
    // long enough for the release to be debounced too.
    task automatic press(input bit en, input bit lk, input bit x);
        @(negedge clk);
        bus.X = x;
        repeat (3) @(negedge clk);
        bus.Enter_n = !en;
        bus.Lock_n  = !lk;
        repeat (6) @(negedge clk);
        bus.Enter_n = 1'b1;
        bus.Lock_n  = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit en;
        bit lk;
        bit x;
        int st;
        int fc;
        int dc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit en, input bit lk, input bit x,
                                input int st, input int fc, input int dc);
        vec_t v;
        v.en = en; v.lk = lk; v.x = x; v.st = st; v.fc = fc; v.dc = dc;
        tbl.push_back(v);
    endfunction

    function automatic void fill_table();
        logic [CODE_LEN-1:0] code_v;
        code_v = CODE;
        // correct code opens on the 7th bit
        for (int i = 0; i < CODE_LEN - 1; i++) add(1, 0, code_v[CODE_LEN-1-i], 0, 0, i + 1);
        add(1, 0, code_v[0], 1, 0, 0);
        add(1, 0, 0, 1, 0, 0);                       // Enter ignored while open
        add(0, 1, 0, 0, 0, 0);                       // Lock relocks
        // all-ones is wrong: no early reject, one failure counted
        for (int i = 0; i < CODE_LEN - 1; i++) add(1, 0, 1, 0, 0, i + 1);
        add(1, 0, 1, 0, 1, 0);
        // three bits then Enter+Lock together: entry abandoned, bit dropped
        for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 1, i + 1);
        add(1, 1, 1, 0, 1, 0);
        // correct code after abandon clears the failure count
        for (int i = 0; i < CODE_LEN - 1; i++) add(1, 0, code_v[CODE_LEN-1-i], 0, 1, i + 1);
        add(1, 0, code_v[0], 1, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        // a wrong entry, partial entry, then Lock keeps the failure count
        for (int i = 0; i < CODE_LEN - 1; i++) add(1, 0, 1, 0, 0, i + 1);
        add(1, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 1, 2);
        add(0, 1, 0, 0, 1, 0);
    endfunction

    // ---------------- main test ----------------
    initial begin
        logic [CODE_LEN-1:0] code_v;
        int locked_cnt, first_lk, last_lk, both_bad;
        int kind;
        bit en, lk, x;

        code_v      = CODE;
        bus.X       = 1'b0;
        bus.Enter_n = 1'b1;
        bus.Lock_n  = 1'b1;

        // reset values while reset is held
        repeat (2) @(negedge clk);
        chk_all("reset", 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();

        // table-driven presses
        fill_table();
        foreach (tbl[i]) begin
            press(tbl[i].en, tbl[i].lk, tbl[i].x);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].fc, tbl[i].dc);
        end

        // bounce: a 3-clock glitch is never accepted
        do_reset();
        bus.X = 1'b1;
        repeat (3) @(negedge clk);
        bus.Enter_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.Enter_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("glitch.digit", int'(bus.Digit_Count), 0);

        // 6-clock hold: exactly one increment, landing 7 clocks after the edge
        bus.Enter_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 6) begin
                chk("hold.edge6.digit", int'(bus.Digit_Count), 0);
                bus.Enter_n = 1'b1;
            end
            if (i == 7) chk("hold.edge7.digit", int'(bus.Digit_Count), 1);
        end
        repeat (12) @(negedge clk);
        chk("hold.once.digit", int'(bus.Digit_Count), 1);

        // lockout: 3 wrong entries, measure its length, Enter ignored during it
        do_reset();
        for (int i = 0; i < 3 * CODE_LEN - 1; i++) press(1, 0, 1);
        chk_all("prelock", 0, 2, CODE_LEN - 1);
        locked_cnt = 0; first_lk = -1; last_lk = -1; both_bad = 0;
        bus.X = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bus.Enter_n = !((i < 6) || (i >= 10 && i < 16));
            @(negedge clk);
            if (bus.Locked_Out === 1'b1) begin
                locked_cnt++;
                if (first_lk < 0) first_lk = i;
                last_lk = i;
            end
            if ((bus.Locked_Out === 1'b1) != (bus.State === 2'd2)) both_bad++;
            if (i == 15) chk_all("lockout.mid", 2, MAX_FAILS, 0);
        end
        chk("lockout.cycles", locked_cnt, LOCKOUT);
        chk("lockout.first", first_lk, 6);
        chk("lockout.last", last_lk, 6 + LOCKOUT - 1);
        chk("lockout.flag_vs_state", both_bad, 0);
        chk_all("lockout.after", 0, 0, 0);

        // asynchronous reset mid-lockout clears outputs with no clock edge
        do_reset();
        for (int i = 0; i < 3 * CODE_LEN; i++) press(1, 0, 1);
        chk_all("arst.before", 2, MAX_FAILS, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst.immediate", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LOCKOUT + 5) @(negedge clk);
        chk_all("arst.after", 0, 0, 0);
        model_reset();

        // random presses against the reference model
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 9);
            lk   = (kind <= 1);
            en   = (kind != 0);
            if (m_bits.size() < CODE_LEN && $urandom_range(0, 3) != 0)
                x = code_v[CODE_LEN - 1 - m_bits.size()];
            else
                x = 1'($urandom_range(0, 1));
            press(en, lk, x);
            model_press(en, lk, x);
            expect_model($sformatf("rand%0d", n));
            if (m_locked) begin
                repeat (LOCKOUT + 5) @(negedge clk);
                m_locked = 1'b0;
                m_fail   = 0;
                expect_model($sformatf("rand%0d.unlock", n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
